sdram_port_arbiter: RTL

- Shares one SDRAM controller port among NUM_CLIENTS requesters with round-robin arbitration.
- Each client sees SDRAM-port semantics: addr/data/byte_en/wr/rd/q/available/ready.
- Sits between multiple client-side engines (video fetch, bus capture, DMA) and a single controller-side port of the SDRAM controller.
- Buffers one request per client and returns read data and a one-cycle ready pulse to the originating client only.

---
 rtl/sdram_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port among NUM_CLIENTS requesters with round-robin arbitration.
// Each client has a one-deep request slot; only one transaction is outstanding downstream.
module sdram_port_arbiter #(
  parameter int NUM_CLIENTS       = 3,
  parameter int PORT_ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH        = 16,
  parameter int DQM_WIDTH         = 2,
  parameter int PORT_OUTPUT_WIDTH = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CLIENTS*PORT_ADDR_WIDTH-1:0]   cl_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]        cl_data,
  input  logic [NUM_CLIENTS*DQM_WIDTH-1:0]         cl_byte_en,
  input  logic [NUM_CLIENTS-1:0]                   cl_wr,
  input  logic [NUM_CLIENTS-1:0]                   cl_rd,
  output logic [NUM_CLIENTS*PORT_OUTPUT_WIDTH-1:0] cl_q,
  output logic [NUM_CLIENTS-1:0]                   cl_available,
  output logic [NUM_CLIENTS-1:0]                   cl_ready,
  output logic [PORT_ADDR_WIDTH-1:0]               dn_addr,
  output logic [DATA_WIDTH-1:0]                    dn_data,
  output logic [DQM_WIDTH-1:0]                     dn_byte_en,
  output logic                                     dn_wr,
  output logic                                     dn_rd,
  input  logic [PORT_OUTPUT_WIDTH-1:0]             dn_q,
  input  logic                                     dn_available,
  input  logic                                     dn_ready
);
  localparam int GW = $clog2(NUM_CLIENTS);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [GW-1:0] LAST = GW'(NUM_CLIENTS - 1);

  logic [1:0]                               state_q, state_d;
  logic [NUM_CLIENTS-1:0]                   pending_q, accept, done_mask, ready_q;
  logic [GW-1:0]                            rr_ptr_q, grant_q, pick;
  logic                                     found, complete, cur_wr_q;
  logic [PORT_ADDR_WIDTH-1:0]               slot_addr_q [NUM_CLIENTS];
  logic [DATA_WIDTH-1:0]                    slot_data_q [NUM_CLIENTS];
  logic [DQM_WIDTH-1:0]                     slot_be_q   [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0]                   slot_wr_q;
  logic [PORT_ADDR_WIDTH-1:0]               dn_addr_q;
  logic [DATA_WIDTH-1:0]                    dn_data_q;
  logic [DQM_WIDTH-1:0]                     dn_be_q;
  logic [NUM_CLIENTS*PORT_OUTPUT_WIDTH-1:0] cl_q_q;

  // Strobes on a client with a request already buffered are dropped.
  assign accept   = (cl_wr | cl_rd) & ~pending_q;
  assign complete = (state_q == S_WAIT) && dn_ready;

  // First pending client at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      if (!found && pending_q[idx[GW-1:0]]) begin
        found = 1'b1;
        pick  = idx[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: if (dn_available) state_d = S_WAIT;
      S_WAIT:  if (dn_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    done_mask = '0;
    if (complete) done_mask[grant_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (accept[i]) begin
        slot_addr_q[i] <= cl_addr[i*PORT_ADDR_WIDTH +: PORT_ADDR_WIDTH];
        slot_data_q[i] <= cl_data[i*DATA_WIDTH +: DATA_WIDTH];
        slot_be_q[i]   <= cl_byte_en[i*DQM_WIDTH +: DQM_WIDTH];
        slot_wr_q[i]   <= cl_wr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      cur_wr_q  <= 1'b0;
      ready_q   <= '0;
      cl_q_q    <= '0;
      dn_addr_q <= '0;
      dn_data_q <= '0;
      dn_be_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q | accept) & ~done_mask;
      ready_q   <= done_mask;
      if (state_q == S_IDLE && found) begin
        grant_q   <= pick;
        cur_wr_q  <= slot_wr_q[pick];
        dn_addr_q <= slot_addr_q[pick];
        dn_data_q <= slot_data_q[pick];
        dn_be_q   <= slot_be_q[pick];
      end
      // Completed client goes last in the next search.
      if (complete) begin
        rr_ptr_q <= (grant_q == LAST) ? '0 : grant_q + 1'b1;
        if (!cur_wr_q) cl_q_q[int'(grant_q)*PORT_OUTPUT_WIDTH +: PORT_OUTPUT_WIDTH] <= dn_q;
      end
    end
  end

  assign cl_available = ~pending_q;
  assign cl_ready     = ready_q;
  assign cl_q         = cl_q_q;
  assign dn_addr      = dn_addr_q;
  assign dn_data      = dn_data_q;
  assign dn_byte_en   = dn_be_q;
  assign dn_wr        = (state_q == S_ISSUE) && dn_available && cur_wr_q;
  assign dn_rd        = (state_q == S_ISSUE) && dn_available && !cur_wr_q;

endmodule
